// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int unsigned DEF_ADDR_W  = 64;
  localparam int unsigned DEF_DATA_W  = 64;
  localparam int unsigned DEF_INSTR_W = 32;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick between IFU and LSU with last-grant tracking.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_if,
  input  logic req_ls,
  output logic gnt_if,
  output logic gnt_ls
);

  logic last_gnt;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (en) begin
      if (req_if && req_ls) begin
        if (last_gnt == OWN_LS) gnt_if = 1'b1;
        else                    gnt_ls = 1'b1;
      end else begin
        gnt_if = req_if;
        gnt_ls = req_ls;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= OWN_LS;
    end else if (gnt_if) begin
      last_gnt <= OWN_IF;
    end else if (gnt_ls) begin
      last_gnt <= OWN_LS;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Shares a single memory port between instruction fetch and load/store,
// one transaction in flight at a time.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  input  logic                if_resp_ready,
  output logic [INSTR_W-1:0]  if_instr,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  input  logic                ls_resp_ready,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t            state;
  logic              owner;
  logic [DATA_W-1:0] rdata_q;
  logic              gnt_if;
  logic              gnt_ls;
  logic              grant_en;

  // Readies are combinational; gating with rst_n keeps them low during reset.
  assign grant_en = (state == IDLE) && rst_n;

  mem_arb_rr u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (grant_en),
    .req_if (if_req_valid),
    .req_ls (ls_req_valid),
    .gnt_if (gnt_if),
    .gnt_ls (gnt_ls)
  );

  assign if_req_ready = gnt_if;
  assign ls_req_ready = gnt_ls;
  assign ls_rdata     = rdata_q;
  assign if_instr     = mem_addr[2] ? rdata_q[INSTR_W +: INSTR_W] : rdata_q[INSTR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      rdata_q       <= '0;
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_ls) begin
            owner         <= OWN_LS;
            mem_addr      <= ls_addr;
            mem_wen       <= ls_wen;
            mem_wdata     <= ls_wdata;
            mem_wmask     <= ls_wmask;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end else if (gnt_if) begin
            owner         <= OWN_IF;
            mem_addr      <= if_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            rdata_q <= mem_rdata;
            if (owner == OWN_LS) ls_resp_valid <= 1'b1;
            else                 if_resp_valid <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          if ((owner == OWN_IF && if_resp_ready) || (owner == OWN_LS && ls_resp_ready)) begin
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 64, address width; DATA_W, default 64, memory data width; INSTR_W, default 32, instruction width.
REQ-002 The module SHALL use one clock; reset is asynchronous and active-low, with ports named clk and rst_n.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_req_valid  in  1  fetch request; if_req_ready  out  1  fetch accepted; if_addr  in  ADDR_W  fetch PC.
REQ-006 if_resp_valid  out  1  instruction available; if_resp_ready  in  1  IFU consumes; if_instr  out  INSTR_W  fetched instruction.
REQ-007 ls_req_valid  in  1; ls_req_ready  out  1; ls_addr  in  ADDR_W; ls_wen  in  1  write when 1; ls_wdata  in  DATA_W; ls_wmask  in  DATA_W/8  byte enables.
REQ-008 ls_resp_valid  out  1  load data or write ack; ls_resp_ready  in  1; ls_rdata  out  DATA_W.
REQ-009 mem_req_valid  out  1; mem_req_ready  in  1; mem_addr  out  ADDR_W; mem_wen  out  1; mem_wdata  out  DATA_W; mem_wmask  out  DATA_W/8.
REQ-010 mem_resp_valid  in  1  read data or write ack; mem_rdata  in  DATA_W.

Function
REQ-011 The block SHALL share one memory port between IFU and LSU with at most one outstanding transaction.
REQ-012 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: on any req_valid, the block SHALL pick the winner, assert that requester's req_ready combinationally in that cycle, latch addr/wen/wdata/wmask and the owner, and go to ISSUE.
REQ-014 Req_ready SHALL be high only in IDLE and only for the winner; the loser's req_ready SHALL stay 0.
REQ-015 When only one request is pending, that requester SHALL win.
REQ-016 When both are pending, the requester not granted last SHALL win (round-robin); last_gnt SHALL update on every grant.
REQ-017 An IFU grant SHALL drive mem_wen=0 and mem_wmask=0 regardless of other inputs.
REQ-018 ISSUE: mem_req_valid SHALL be 1 with the latched fields held stable; on mem_req_ready=1 the FSM SHALL go to WAIT.
REQ-019 WAIT: on mem_resp_valid=1 the block SHALL latch mem_rdata and go to RESP.
REQ-020 mem_resp_valid SHALL be ignored in every state except WAIT.
REQ-021 RESP: the owner's resp_valid SHALL be 1 and resp data held stable; on the owner's resp_ready=1 the FSM SHALL return to IDLE.
REQ-022 IDLE SHALL be reachable before a new grant, so back-to-back transactions cost one IDLE cycle.
REQ-023 if_instr SHALL equal the latched rdata[63:32] when latched addr[2]=1, else rdata[31:0].
REQ-024 ls_rdata SHALL equal the full latched rdata; for writes, ls_resp_valid is an ack and ls_rdata content is don't-care.
REQ-025 Minimum latency SHALL be: grant at cycle 0, mem_req_valid at cycle 1, WAIT at cycle 2 at the earliest, resp_valid one cycle after mem_resp_valid.
REQ-026 Requester inputs SHALL be ignored outside the IDLE grant cycle.

Reset
REQ-027 On rst_n=0 the block SHALL, immediately, set state=IDLE and last_gnt=LSU (so IFU wins the first tie), and drive every out port to 0.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no response to either requester.
REQ-029 Reset deassertion SHALL be synchronized externally; the block SHALL act on the first clk edge after release.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the owner ID constants (OWN_IF, OWN_LS) and the default widths.
REQ-031 A sub-module mem_arb_rr SHALL implement the two-way round-robin pick and last_gnt register.

Verification
REQ-032 IFU-only: if_addr=0x80000004, mem returns rdata=0x1111_2222_3333_4444 -> if_instr=0x11112222.
REQ-033 Simultaneous first requests -> IFU granted first; with LSU still pending, the next grant goes to LSU; two more simultaneous requests -> IFU then LSU.
REQ-034 LSU write: addr=0x80001000, wdata=0xDEADBEEF_CAFEF00D, wmask=0x0F -> exact mem fields, one ls_resp_valid ack, and if_resp_valid stays 0.
REQ-035 Backpressure: mem_req_ready low for 3 cycles and ls_resp_ready low for 2 cycles -> mem and response fields stable throughout, single handshake each.
REQ-036 rst_n pulsed low in WAIT -> all outputs 0 at once, a later stray mem_resp_valid ignored, next IFU request served normally.
